// File: rtl/inv_key_expansion.sv
// inv_key_expansion: AES-128 round keys 10..0 with valid/next handshake.
// Define INV_KE_FWD_PRECOMPUTE_EN to load the cipher key and derive round 10 internally.
module inv_key_expansion #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_in,
  input  logic [DATA_WIDTH-1:0] key_in_0,
  input  logic [DATA_WIDTH-1:0] key_in_1,
  input  logic [DATA_WIDTH-1:0] key_in_2,
  input  logic [DATA_WIDTH-1:0] key_in_3,
  input  logic                  next_in,
  output logic [DATA_WIDTH-1:0] rk_out_0,
  output logic [DATA_WIDTH-1:0] rk_out_1,
  output logic [DATA_WIDTH-1:0] rk_out_2,
  output logic [DATA_WIDTH-1:0] rk_out_3,
  output logic [3:0]            round_out,
  output logic                  rk_valid_out,
  output logic                  busy_out,
  output logic                  done_out
);
  typedef enum logic [1:0] {IDLE, FWD, OUT} state_t;
  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  localparam logic [7:0] RCON [16] = '{
    8'h00,8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36,8'h00,8'h00,8'h00,8'h00,8'h00
  };
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {SBOX[r[31:24]], SBOX[r[23:16]], SBOX[r[15:8]], SBOX[r[7:0]]};
  endfunction
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] w_q [4];
  logic [DATA_WIDTH-1:0] w_d [4];
  logic [3:0] round_q, round_d, rc_idx;
  logic valid_q, busy_q, done_q, done_d;
  logic [31:0] sb_in, t;
  logic [31:0] inv [4];
`ifdef INV_KE_FWD_PRECOMPUTE_EN
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] fwd [4];
  // One S-box path serves both directions; FWD and OUT never overlap.
  assign sb_in  = state_q == FWD ? w_q[3] : w_q[3] ^ w_q[2];
  assign rc_idx = state_q == FWD ? cnt_q : round_q;
  assign fwd[0] = w_q[0] ^ t;
  assign fwd[1] = w_q[1] ^ fwd[0];
  assign fwd[2] = w_q[2] ^ fwd[1];
  assign fwd[3] = w_q[3] ^ fwd[2];
`else
  assign sb_in  = w_q[3] ^ w_q[2];
  assign rc_idx = round_q;
`endif
  assign t      = sub_rot(sb_in) ^ {RCON[rc_idx], 24'h0};
  assign inv[3] = w_q[3] ^ w_q[2];
  assign inv[2] = w_q[2] ^ w_q[1];
  assign inv[1] = w_q[1] ^ w_q[0];
  assign inv[0] = w_q[0] ^ t;
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    round_d = round_q;
    done_d  = 1'b0;
`ifdef INV_KE_FWD_PRECOMPUTE_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: if (start_in) begin
        w_d = '{key_in_0, key_in_1, key_in_2, key_in_3};
`ifdef INV_KE_FWD_PRECOMPUTE_EN
        state_d = FWD;
        cnt_d   = 4'd1;
`else
        state_d = OUT;
        round_d = 4'd10;
`endif
      end
`ifdef INV_KE_FWD_PRECOMPUTE_EN
      FWD: begin
        w_d   = fwd;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd10) begin
          state_d = OUT;
          round_d = 4'd10;
        end
      end
`endif
      OUT: if (next_in) begin
        if (round_q != 4'd0) begin
          w_d     = inv;
          round_d = round_q - 4'd1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '{default: '0};
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef INV_KE_FWD_PRECOMPUTE_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      round_q <= round_d;
      valid_q <= state_d == OUT;
      busy_q  <= state_d != IDLE;
      done_q  <= done_d;
`ifdef INV_KE_FWD_PRECOMPUTE_EN
      cnt_q   <= cnt_d;
`endif
    end
  end
  assign rk_out_0     = w_q[0];
  assign rk_out_1     = w_q[1];
  assign rk_out_2     = w_q[2];
  assign rk_out_3     = w_q[3];
  assign round_out    = round_q;
  assign rk_valid_out = valid_q;
  assign busy_out     = busy_q;
  assign done_out     = done_q;
endmodule

// File: tb/tb_inv_key_expansion.sv
// tb_inv_key_expansion: random and directed checks against an AES key-schedule model.
module tb_inv_key_expansion;
`ifdef INV_KE_FWD_PRECOMPUTE_EN
  localparam int LAT = 11;
  localparam int FWD_CYC = 10;
`else
  localparam int LAT = 1;
  localparam int FWD_CYC = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start_in = 1'b0, next_in = 1'b0;
  logic [31:0] key_in [4] = '{default: '0};
  logic [31:0] rk [4];
  logic [3:0] round_out;
  logic rk_valid_out, busy_out, done_out;
  logic [127:0] cur;
  inv_key_expansion #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in),
    .key_in_0(key_in[0]), .key_in_1(key_in[1]), .key_in_2(key_in[2]), .key_in_3(key_in[3]),
    .next_in(next_in),
    .rk_out_0(rk[0]), .rk_out_1(rk[1]), .rk_out_2(rk[2]), .rk_out_3(rk[3]),
    .round_out(round_out), .rk_valid_out(rk_valid_out), .busy_out(busy_out), .done_out(done_out)
  );
  assign cur = {rk[0], rk[1], rk[2], rk[3]};
  always #5 clk = ~clk;
  int errs = 0, checks = 0;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  // S-box derived from GF(2^8) inversion plus affine map, independent of any table.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    if (x == 8'h00) r = 8'h00;
    return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  endfunction
  logic [127:0] tb_sched [11];
  task automatic expand(input logic [127:0] ck);
    logic [31:0] w [44];
    logic [31:0] tw;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = ck[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {tw[23:0], tw[31:24]};
        tw = {sbox(tw[31:24]), sbox(tw[23:16]), sbox(tw[15:8]), sbox(tw[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int r = 0; r < 11; r++) tb_sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask
  // Transaction-level model: which key is on offer, and whether a run is live.
  logic m_busy, m_done;
  logic [3:0] m_round;
  int m_fwd;
  logic [127:0] m_sched [11];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_round <= 4'd0; m_fwd <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start_in) begin
          m_busy <= 1'b1; m_fwd <= FWD_CYC; m_round <= 4'd10; m_sched <= tb_sched;
        end
      end else if (m_fwd > 0) m_fwd <= m_fwd - 1;
      else if (next_in) begin
        if (m_round > 0) m_round <= m_round - 4'd1;
        else begin
          m_busy <= 1'b0; m_done <= 1'b1; m_round <= 4'd0;
        end
      end
    end
  end
  always @(negedge clk) begin
    chk("valid", 128'(rk_valid_out), 128'(m_busy && m_fwd == 0));
    chk("busy", 128'(busy_out), 128'(m_busy));
    chk("done", 128'(done_out), 128'(m_done));
    chk("round", 128'(round_out), 128'((m_busy && m_fwd == 0) ? m_round : 4'd0));
    if (m_busy && m_fwd == 0) chk("rk", cur, m_sched[m_round]);
  end
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic run(input logic [127:0] ck);
    logic [127:0] k;
    expand(ck);
`ifdef INV_KE_FWD_PRECOMPUTE_EN
    k = ck;
`else
    k = tb_sched[10];
`endif
    for (int i = 0; i < 4; i++) key_in[i] = k[127-32*i -: 32];
    start_in = 1'b1;
    cyc();
    start_in = 1'b0;
  endtask
  task automatic wait_round(input logic [3:0] r);
    int n = 0;
    while (!(rk_valid_out && round_out == r) && n < 100) begin
      cyc();
      n++;
    end
    chk("wait_round_timeout", 128'(n < 100), 128'(1));
  endtask
  task automatic wait_done(input bit rnd);
    int n = 0;
    while (!done_out && n < 400) begin
      next_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      n++;
    end
    chk("wait_done_timeout", 128'(n < 400), 128'(1));
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", {cur[127:5], round_out, rk_valid_out}, '0);
    chk("rst_flags", 128'({busy_out, done_out}), 128'(0));
    #1;
    rst_n = 1'b1;
    cyc();
  endtask
  localparam logic [127:0] CK = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  initial begin
    logic [127:0] saved, sched_keep [11];
    int n;
    repeat (3) cyc();
    chk("reset_state", {cur, round_out, rk_valid_out, busy_out, done_out}, '0);
    rst_n = 1'b1;
    cyc();
    chk("sbox_00", 128'(sbox(8'h00)), 128'(8'h63));
    chk("sbox_53", 128'(sbox(8'h53)), 128'(8'hed));
    expand(CK);
    chk("model_rk10", tb_sched[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_rk9", tb_sched[9], 128'hac7766f319fadc2128d12941575c006e);
    chk("model_rk1", tb_sched[1], 128'ha0fafe1788542cb123a339392a6c7605);
    next_in = 1'b1;
    run(CK);
    n = 1;
    while (!rk_valid_out && n < 30) begin
      cyc();
      n++;
    end
    chk("start_latency", 128'(n), 128'(LAT));
    chk("dut_rk10", {round_out, cur}, {4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
    cyc();
    chk("dut_rk9", {round_out, cur}, {4'd9, 128'hac7766f319fadc2128d12941575c006e});
    wait_round(4'd1);
    chk("dut_rk1", cur, 128'ha0fafe1788542cb123a339392a6c7605);
    cyc();
    chk("dut_rk0", {round_out, rk_valid_out, cur}, {4'd0, 1'b1, CK});
    cyc();
    chk("done_pulse", 128'({done_out, busy_out, rk_valid_out}), 128'(3'b100));
    cyc();
    chk("done_single", 128'(done_out), 128'(0));
    run(rnd128());
    wait_round(4'd7);
    next_in = 1'b0;
    saved = cur;
    repeat (5) cyc();
    chk("bp_hold", {round_out, rk_valid_out, cur}, {4'd7, 1'b1, saved});
    next_in = 1'b1;
    cyc();
    chk("bp_resume", {round_out, cur}, {4'd6, tb_sched[6]});
    wait_done(1'b0);
    cyc();
    run(rnd128());
    sched_keep = tb_sched;
    wait_round(4'd4);
    for (int i = 0; i < 4; i++) key_in[i] = $urandom;
    start_in = 1'b1;
    cyc();
    start_in = 1'b0;
    chk("start_ignored", {round_out, busy_out, cur}, {4'd3, 1'b1, sched_keep[3]});
    wait_done(1'b0);
    cyc();
    run(rnd128());
    wait_round(4'd5);
    mid_reset();
    run(rnd128());
`ifdef INV_KE_FWD_PRECOMPUTE_EN
    repeat (3) cyc();
    mid_reset();
    run(rnd128());
`endif
    wait_done(1'b1);
    start_in = 1'b1;
    cyc();
    start_in = 1'b0;
    chk("b2b_busy", 128'(busy_out), 128'(1));
    wait_round(4'd10);
    chk("b2b_rk10", cur, tb_sched[10]);
    wait_done(1'b1);
    cyc();
    for (int r = 0; r < 4; r++) begin
      run(rnd128());
      wait_done(1'b1);
      repeat ($urandom_range(0, 2)) cyc();
    end
    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
